// File: rtl/apb_csb_bridge.sv
// APB slave to CSB master bridge: one transfer in flight, read timeout,
// optional non-posted writes, and a mandatory HOLD wait state before DONE.
module apb_csb_bridge #(
    parameter int unsigned TIMEOUT    = 1024,
    parameter bit          WR_NPOSTED = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        csb_valid_o,
    input  logic        csb_ready_i,
    output logic [15:0] csb_addr_o,
    output logic [31:0] csb_wdat_o,
    output logic        csb_write_o,
    output logic        csb_nposted_o,
    input  logic        csb_rvalid_i,
    input  logic [31:0] csb_rdata_i,
    input  logic        csb_wr_complete_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] LP_TMO_DATA = 32'hDEAD_DEAD;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [31:0] r_wdat;
    logic [31:0] r_prdata;
    logic [31:0] w_prdata_nxt;
    logic        r_write;
    logic        r_err;
    logic        w_err_nxt;
    logic        w_setup;
    logic        w_rsp;
    logic        w_unused;

    assign w_unused = ^{paddr_i[31:18], paddr_i[1:0]};
    assign w_setup  = (r_state == S_IDLE) & psel_i & ~penable_i;

    // Only the completion type matching the latched transfer counts
    assign w_rsp = r_write ? (WR_NPOSTED & csb_wr_complete_i)
                           : csb_rvalid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdat   <= '0;
            r_write  <= 1'b0;
            r_cnt    <= '0;
            r_prdata <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nxt;
            r_prdata <= w_prdata_nxt;
            r_err    <= w_err_nxt;
            if (w_setup) begin
                r_addr  <= paddr_i[17:2];
                r_wdat  <= pwdata_i;
                r_write <= pwrite_i;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_nxt    = r_cnt;
        w_prdata_nxt = r_prdata;
        w_err_nxt    = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_setup) w_next = S_REQ;
            end
            S_REQ: begin
                if (csb_ready_i) begin
                    if (r_write && !WR_NPOSTED) begin
                        w_next = S_HOLD;
                    end else if (w_rsp) begin
                        w_next = S_HOLD;
                        if (!r_write) w_prdata_nxt = csb_rdata_i;
                    end else begin
                        w_next    = S_WAIT;
                        w_cnt_nxt = '0;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + 16'd1;
                // A response in the final wait cycle still wins over timeout
                if (w_rsp) begin
                    w_next = S_HOLD;
                    if (!r_write) w_prdata_nxt = csb_rdata_i;
                end else if (r_cnt == LP_TMO_LAST) begin
                    w_next    = S_HOLD;
                    w_err_nxt = 1'b1;
                    if (!r_write) w_prdata_nxt = LP_TMO_DATA;
                end
            end
            S_HOLD: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next    = S_IDLE;
                w_err_nxt = 1'b0;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign csb_valid_o   = (r_state == S_REQ);
    assign csb_addr_o    = r_addr;
    assign csb_wdat_o    = r_wdat;
    assign csb_write_o   = r_write;
    assign csb_nposted_o = r_write & WR_NPOSTED;
    assign pready_o      = (r_state == S_DONE);
    assign pslverr_o     = (r_state == S_DONE) & r_err;
    assign prdata_o      = r_prdata;

endmodule

// File: tb/tb_apb_csb_bridge.sv
// Randomized bench for apb_csb_bridge: posted (k=0) and non-posted (k=1)
// instances, expectations computed from transfer-level timing rules.
module tb_apb_csb_bridge;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic        cready  [2];
    logic        crvalid [2];
    logic        cwrc    [2];
    logic [31:0] crdata  [2];

    logic [31:0] prdata0, prdata1, cwdat0, cwdat1;
    logic [15:0] caddr0, caddr1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic        cvalid0, cvalid1, cwrite0, cwrite1, cnp0, cnp1;

    logic [31:0] exp_rd [2];
    int          n_pass  = 0;
    int          n_total = 0;

    logic [31:0] s_prdata, s_wdat;
    logic [15:0] s_addr;
    logic        s_pready, s_pslverr, s_valid, s_write, s_np;

    apb_csb_bridge #(.TIMEOUT(TMO), .WR_NPOSTED(1'b0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .psel_i(psel[0]), .penable_i(penable[0]), .pwrite_i(pwrite[0]),
        .paddr_i(paddr[0]), .pwdata_i(pwdata[0]),
        .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0),
        .csb_valid_o(cvalid0), .csb_ready_i(cready[0]),
        .csb_addr_o(caddr0), .csb_wdat_o(cwdat0),
        .csb_write_o(cwrite0), .csb_nposted_o(cnp0),
        .csb_rvalid_i(crvalid[0]), .csb_rdata_i(crdata[0]),
        .csb_wr_complete_i(cwrc[0])
    );

    apb_csb_bridge #(.TIMEOUT(TMO), .WR_NPOSTED(1'b1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .psel_i(psel[1]), .penable_i(penable[1]), .pwrite_i(pwrite[1]),
        .paddr_i(paddr[1]), .pwdata_i(pwdata[1]),
        .prdata_o(prdata1), .pready_o(pready1), .pslverr_o(pslverr1),
        .csb_valid_o(cvalid1), .csb_ready_i(cready[1]),
        .csb_addr_o(caddr1), .csb_wdat_o(cwdat1),
        .csb_write_o(cwrite1), .csb_nposted_o(cnp1),
        .csb_rvalid_i(crvalid[1]), .csb_rdata_i(crdata[1]),
        .csb_wr_complete_i(cwrc[1])
    );

    task automatic sample(input int k);
        if (k == 0) begin
            s_prdata = prdata0; s_pready = pready0; s_pslverr = pslverr0;
            s_valid = cvalid0; s_addr = caddr0; s_wdat = cwdat0;
            s_write = cwrite0; s_np = cnp0;
        end else begin
            s_prdata = prdata1; s_pready = pready1; s_pslverr = pslverr1;
            s_valid = cvalid1; s_addr = caddr1; s_wdat = cwdat1;
            s_write = cwrite1; s_np = cnp1;
        end
    endtask

    task automatic drive_idle(input int k);
        psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
        paddr[k] = '0; pwdata[k] = '0; cready[k] = 1'b0;
        crvalid[k] = 1'b0; cwrc[k] = 1'b0; crdata[k] = '0;
    endtask

    // d: REQ cycles before acceptance; r: response cycles after acceptance
    // (0 = same cycle, > TMO = never answered)
    task automatic run_xfer(input int k, input bit wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rdata, input int d, input int r,
                            input bit chaos, input bit stray);
        int ta, hold, done;
        bit posted, err, p;
        logic [31:0] exp_after, e_prd;
        logic [15:0] exp_addr;
        logic e_valid, e_ready, e_err;
        posted = wr && (k == 0);
        ta = 1 + d;
        if (posted) hold = ta + 1;
        else if (r > TMO) hold = ta + TMO + 1;
        else hold = ta + r + 1;
        done = hold + 1;
        err = !posted && (r > TMO);
        exp_after = wr ? exp_rd[k] : (err ? 32'hDEAD_DEAD : rdata);
        exp_addr = addr[17:2];
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = data;
        cready[k] = 1'b0; crvalid[k] = 1'b0; cwrc[k] = 1'b0;
        for (int t = 1; t <= done + 1; t++) begin
            @(negedge clk);
            sample(k);
            e_valid = (t <= ta);
            e_ready = (t == done);
            e_err = (t == done) && err;
            e_prd = (t >= hold) ? exp_after : exp_rd[k];
            n_total++;
            if (s_valid !== e_valid)
                $display("FAIL csb_valid k=%0d t=%0d got %b exp %b", k, t, s_valid, e_valid);
            else n_pass++;
            n_total++;
            if (s_pready !== e_ready)
                $display("FAIL pready k=%0d t=%0d got %b exp %b", k, t, s_pready, e_ready);
            else n_pass++;
            n_total++;
            if (s_pslverr !== e_err)
                $display("FAIL pslverr k=%0d t=%0d got %b exp %b", k, t, s_pslverr, e_err);
            else n_pass++;
            n_total++;
            if (s_prdata !== e_prd)
                $display("FAIL prdata k=%0d t=%0d got %h exp %h", k, t, s_prdata, e_prd);
            else n_pass++;
            if (s_valid === 1'b1) begin
                n_total++;
                if (s_addr !== exp_addr || s_wdat !== data ||
                    s_write !== wr || s_np !== (wr && k == 1))
                    $display("FAIL csb_fields k=%0d t=%0d got %h/%h/%b/%b exp %h/%h/%b/%b",
                             k, t, s_addr, s_wdat, s_write, s_np,
                             exp_addr, data, wr, (wr && k == 1));
                else n_pass++;
            end
            cready[k] = (t == ta) ? 1'b1 :
                        ((t > ta) ? 1'($urandom_range(0, 1)) : 1'b0);
            p = !posted && (r <= TMO) && (t == ta + r);
            crdata[k] = p ? rdata : $urandom;
            if (stray && ((t == 1 && t < ta) || t == hold)) p = 1'b1;
            crvalid[k] = wr ? 1'b0 : p;
            cwrc[k] = wr ? p : 1'b0;
            if (t >= done) begin
                psel[k] = 1'b0; penable[k] = 1'b0;
            end else if (chaos) begin
                psel[k] = 1'($urandom_range(0, 1));
                penable[k] = 1'($urandom_range(0, 1));
                pwrite[k] = 1'($urandom_range(0, 1));
                paddr[k] = $urandom;
                pwdata[k] = $urandom;
            end else begin
                psel[k] = 1'b1; penable[k] = 1'b1;
            end
        end
        cready[k] = 1'b0; crvalid[k] = 1'b0; cwrc[k] = 1'b0;
        exp_rd[k] = exp_after;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            sample(k);
            n_total++;
            if ({s_prdata, s_pready, s_pslverr, s_valid, s_addr,
                 s_wdat, s_write, s_np} !== '0)
                $display("FAIL %s k=%0d got %h/%b/%b/%b/%h/%h/%b/%b exp all 0",
                         tag, k, s_prdata, s_pready, s_pslverr, s_valid,
                         s_addr, s_wdat, s_write, s_np);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
    endtask

    task automatic test_posted_write();
        run_xfer(0, 1'b1, 32'h0000_100C, 32'h0000_0001, $urandom, 0, 0, 1'b0, 1'b0);
        run_xfer(0, 1'b1, 32'hFFFC_0003, $urandom, $urandom, 2, 0, 1'b0, 1'b1);
    endtask

    task automatic test_read();
        run_xfer(0, 1'b0, 32'h0000_1004, $urandom, 32'hA5A5_0001, 0, 3, 1'b0, 1'b0);
        run_xfer(0, 1'b0, 32'h0003_FFFC, $urandom, $urandom, 1, 0, 1'b0, 1'b1);
        run_xfer(1, 1'b0, 32'h0000_0040, $urandom, $urandom, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_ready_stall();
        run_xfer(0, 1'b1, 32'h0000_2220, 32'h1234_5678, $urandom, 5, 0, 1'b0, 1'b0);
        run_xfer(0, 1'b0, 32'h0000_2224, $urandom, 32'h0BAD_F00D, 5, 1, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        run_xfer(0, 1'b0, 32'h0000_3000, $urandom, $urandom, 1, TMO + 5, 1'b0, 1'b1);
        run_xfer(0, 1'b0, 32'h0000_3004, $urandom, 32'h7777_0001, 0, TMO, 1'b0, 1'b0);
        run_xfer(0, 1'b0, 32'h0000_3008, $urandom, $urandom, 0, TMO + 1, 1'b0, 1'b0);
    endtask

    task automatic test_nposted();
        run_xfer(1, 1'b1, 32'hFFFF_0008, 32'hCAFE_0001, $urandom, 0, 0, 1'b0, 1'b0);
        run_xfer(1, 1'b1, 32'h0001_0010, 32'hCAFE_0002, $urandom, 2, 4, 1'b1, 1'b1);
    endtask

    task automatic test_idle_ignore();
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b1; penable[k] = 1'b1; pwrite[k] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                paddr[k] = $urandom;
                cready[k] = 1'($urandom_range(0, 1));
                crvalid[k] = 1'($urandom_range(0, 1));
                cwrc[k] = 1'($urandom_range(0, 1));
                crdata[k] = $urandom;
                @(negedge clk);
                sample(k);
                n_total++;
                if (s_valid !== 1'b0 || s_pready !== 1'b0 || s_prdata !== exp_rd[k])
                    $display("FAIL idle_ignore k=%0d c=%0d got %b/%b/%h exp 0/0/%h",
                             k, c, s_valid, s_pready, s_prdata, exp_rd[k]);
                else n_pass++;
            end
            drive_idle(k);
        end
    endtask

    task automatic test_random();
        int k, d, r;
        bit wr;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            d = $urandom_range(0, 4);
            r = $urandom_range(0, TMO + 3);
            if (wr && k == 1 && r > TMO) r = TMO;
            run_xfer(k, wr, $urandom, $urandom, $urandom, d, r,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0;
        paddr[0] = 32'h0000_5000;
        @(negedge clk);
        penable[0] = 1'b1; cready[0] = 1'b1;
        @(negedge clk);
        cready[0] = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        drive_idle(0);
        drive_idle(1);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sample(0);
            n_total++;
            if (s_valid !== 1'b0 || s_pready !== 1'b0)
                $display("FAIL post_reset_idle c=%0d got %b/%b exp 0/0",
                         c, s_valid, s_pready);
            else n_pass++;
        end
        run_xfer(0, 1'b0, 32'h0000_5004, $urandom, 32'h1357_9BDF, 0, 2, 1'b0, 1'b0);
    endtask

    initial begin
        drive_idle(0);
        drive_idle(1);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        test_reset();
        test_posted_write();
        test_read();
        test_ready_stall();
        test_timeout();
        test_nposted();
        test_idle_ignore();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
